// File: rtl/timer_arbiter.sv
// timer_arbiter: round-robin sharing of one load/down-count timer between N requesters,
// sequencing LOAD -> COUNT -> DONE for each granted job.
module timer_arbiter #(
  parameter int N  = 4,
  parameter int DW = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    req,
  input  logic [N*DW-1:0] dur,
  output logic [N-1:0]    grant,
  output logic [N-1:0]    done,
  output logic            busy,
  output logic            tm_pe,
  output logic            tm_ce,
  output logic [DW-1:0]   tm_din,
  input  logic            tm_eq
);
  localparam int IW = $clog2(N);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] LOAD  = 2'd1;
  localparam logic [1:0] COUNT = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;
  logic [1:0]    state_q, state_d;
  logic [IW-1:0] ptr_q, ptr_d, own_q, own_d, pick, nxt;
  logic [DW-1:0] dur_q, dur_d;
  logic [N-1:0]  oh;
  logic          found;
  // Scan from the far end so the last hit is the first requester at or after ptr.
  always_comb begin
    pick = '0;
    found = 1'b0;
    for (int k = N - 1; k >= 0; k--)
      if (req[(int'(ptr_q) + k) % N]) begin
        pick = IW'((int'(ptr_q) + k) % N);
        found = 1'b1;
      end
  end
  assign nxt = (own_q == IW'(N - 1)) ? '0 : own_q + 1'b1;
  assign oh  = {{(N-1){1'b0}}, 1'b1} << own_q;
  always_comb begin
    state_d = state_q;
    ptr_d = ptr_q;
    own_d = own_q;
    dur_d = dur_q;
    case (state_q)
      IDLE: if (found) begin
        state_d = LOAD;
        own_d = pick;
        dur_d = dur[int'(pick)*DW +: DW];
      end
      LOAD: state_d = COUNT;
      COUNT: if (tm_eq) state_d = DONE;
        else if (!req[own_q]) begin
          state_d = IDLE;
          ptr_d = nxt;
        end
      default: begin
        state_d = IDLE;
        ptr_d = nxt;
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      ptr_q <= '0;
      own_q <= '0;
      dur_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
      own_q <= own_d;
      dur_q <= dur_d;
    end
  end
  assign busy   = state_q != IDLE;
  assign grant  = busy ? oh : '0;
  assign done   = (state_q == DONE) ? oh : '0;
  assign tm_pe  = state_q == LOAD;
  assign tm_ce  = (state_q == COUNT) && !tm_eq;
  assign tm_din = busy ? dur_q : '0;
endmodule

// File: tb/tb_timer_arbiter.sv
// tb_timer_arbiter: job-timeline reference model plus directed and random requester traffic.
module tb_timer_arbiter;
  localparam int N = 4, DW = 8;
  logic clk = 0, rst = 0;
  logic [N-1:0] req = '0;
  logic [N*DW-1:0] dur = '0;
  logic [N-1:0] grant, done;
  logic busy, tm_pe, tm_ce, tm_eq;
  logic [DW-1:0] tm_din;
  logic [DW-1:0] cnt = '0;
  int errors = 0, checks = 0;
  bit chk_en = 0;
  always #5 clk = ~clk;
  timer_arbiter #(.N(N), .DW(DW)) dut (
    .clk(clk), .rst(rst), .req(req), .dur(dur), .grant(grant), .done(done), .busy(busy),
    .tm_pe(tm_pe), .tm_ce(tm_ce), .tm_din(tm_din), .tm_eq(tm_eq)
  );
  // Shared timer datapath: parallel-load down-counter with zero compare.
  always @(posedge clk) cnt <= tm_pe ? tm_din : tm_ce ? cnt - 1'b1 : cnt;
  assign tm_eq = cnt == '0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  // Model: a job is (owner, duration D, cycle t since arbitration); LOAD at t=1,
  // count during t=2..D+1, compare hit at D+2, done at D+3.
  bit m_busy = 0;
  int m_own = 0, m_d = 0, m_t = 0, m_ptr = 0;
  function automatic int rr_pick(input int p, input logic [N-1:0] r);
    for (int k = 0; k < N; k++) if (r[(p + k) % N]) return (p + k) % N;
    return 0;
  endfunction
  always @(posedge clk) begin
    if (!rst) begin
      m_busy <= 0;
      m_ptr <= 0;
      m_t <= 0;
    end else if (!m_busy) begin
      if (req != '0) begin
        m_busy <= 1;
        m_own <= rr_pick(m_ptr, req);
        m_d <= int'(dur[rr_pick(m_ptr, req)*DW +: DW]);
        m_t <= 1;
      end
    end else if (m_t == m_d + 3 || (m_t >= 2 && m_t <= m_d + 1 && !req[m_own])) begin
      m_busy <= 0;
      m_ptr <= (m_own + 1) % N;
    end else m_t <= m_t + 1;
  end
  logic [N-1:0] e_grant, e_done;
  logic [DW-1:0] e_din;
  always @(negedge clk) if (chk_en) begin
    e_grant = m_busy ? (N'(1) << m_own) : '0;
    e_done = (m_busy && m_t == m_d + 3) ? e_grant : '0;
    e_din = m_busy ? m_d[DW-1:0] : '0;
    chk("grant", grant, e_grant);
    chk("done", done, e_done);
    chk("busy", busy, m_busy);
    chk("tm_pe", tm_pe, m_busy && m_t == 1);
    chk("tm_ce", tm_ce, m_busy && m_t >= 2 && m_t < m_d + 2);
    chk("tm_din", tm_din, e_din);
  end
  task automatic do_reset();
    rst = 0;
    @(negedge clk);
    rst = 1;
  endtask
  task automatic serve(input logic [N-1:0] r, output logic [31:0] order);
    int n = 0, last_load = 0, last_done = -1, c = 0, d = 0;
    order = '0;
    req = r;
    while ((req != '0 || busy) && c < 400) begin
      @(negedge clk);
      c++;
      if (tm_pe) begin
        if (last_done >= 0) chk("load_gap", c - last_done, 2);
        order[4*n +: 4] = grant;
        n++;
        last_load = c;
        d = int'(tm_din);
      end
      if (done != '0) begin
        chk("done_latency", c - last_load, d + 2);
        last_done = c;
        req = req & ~done;
      end
    end
    if (c >= 400) chk("serve_timeout", c, 0);
  endtask
  function automatic logic [DW-1:0] rnd_dur();
    return ($urandom_range(0, 31) == 0) ? 8'hFF : DW'($urandom_range(0, 12));
  endfunction
  initial begin
    int nb, nc, nd, j;
    logic [31:0] ord;
    @(negedge clk);
    @(negedge clk);
    rst = 1;
    chk_en = 1;
    chk("reset_busy", busy, 0);
    chk("reset_grant", grant, 0);
    dur = {8'd0, 8'd5, 8'd0, 8'd0};
    req = 4'b0100;
    nb = 0;
    nc = 0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (c == 1) begin
        chk("t1_pe", tm_pe, 1);
        chk("t1_din", tm_din, 5);
      end
      if (c == 8) begin
        chk("t1_done", done, 4'b0100);
        req = '0;
      end
      nb += int'(busy);
      nc += int'(tm_ce);
    end
    chk("t1_busy_cycles", nb, 8);
    chk("t1_ce_cycles", nc, 5);
    do_reset();
    dur = {8'd2, 8'd2, 8'd2, 8'd2};
    serve(4'b1111, ord);
    chk("t2_order", ord, 32'h8421);
    serve(4'b0010, ord);
    chk("t3_first", ord, 32'h2);
    serve(4'b0011, ord);
    chk("t3_wrap_order", ord, 32'h21);
    dur = {8'd2, 8'd2, 8'd2, 8'd0};
    req = 4'b0001;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      if (c == 1) chk("t4_pe", tm_pe, 1);
      if (c == 2) begin
        chk("t4_count_busy", busy, 1);
        chk("t4_count_ce", tm_ce, 0);
      end
      if (c == 3) begin
        chk("t4_done", done, 4'b0001);
        req = '0;
      end
    end
    dur = {8'd3, 8'd0, 8'd20, 8'd0};
    req = 4'b1010;
    nd = 0;
    for (int c = 1; c <= 15; c++) begin
      @(negedge clk);
      nd += int'(done[1]);
      if (c == 1) chk("t5_grant1", grant, 4'b0010);
      if (c == 6) req = 4'b1000;
      if (c == 7) chk("t5_idle", busy, 0);
      if (c == 8) begin
        chk("t5_grant3", grant, 4'b1000);
        chk("t5_pe3", tm_pe, 1);
      end
      if (c == 13) begin
        chk("t5_done3", done, 4'b1000);
        req = '0;
      end
    end
    chk("t5_no_done1", nd, 0);
    dur = {8'd4, 8'd3, 8'd10, 8'd2};
    serve(4'b0100, ord);
    chk("t6_pre", ord, 32'h4);
    req = 4'b0010;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      if (c == 4) begin
        chk("t6_counting", tm_ce, 1);
        rst = 0;
      end
      if (c == 5) begin
        chk("t6_grant", grant, 0);
        chk("t6_done", done, 0);
        chk("t6_ce", tm_ce, 0);
        chk("t6_pe", tm_pe, 0);
        chk("t6_busy", busy, 0);
        rst = 1;
        req = 4'b1111;
      end
      if (c == 6) begin
        chk("t6_ptr_cleared", grant, 4'b0001);
        req = '0;
      end
    end
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      if (!rst) rst = 1;
      else if ($urandom_range(0, 499) == 0) rst = 0;
      for (int i = 0; i < N; i++) begin
        if (done[i]) begin
          if ($urandom_range(0, 3) != 0) req[i] = 0;
        end else if (!req[i]) begin
          if ($urandom_range(0, 7) == 0) begin
            req[i] = 1;
            dur[i*DW +: DW] = rnd_dur();
          end
        end else if ($urandom_range(0, 63) == 0) req[i] = 0;
      end
      if ($urandom_range(0, 15) == 0) begin
        j = int'($urandom_range(0, N - 1));
        dur[j*DW +: DW] = rnd_dur();
      end
    end
    rst = 1;
    req = '0;
    repeat (5) @(negedge clk);
    chk("final_idle", busy, 0);
    chk_en = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
